// File: rtl/div_pkg.sv
// Shared definitions for the 32-bit signed restoring divider:
// operand width, iteration count and the control FSM states.
package div_pkg;

    localparam int DIV_WIDTH      = 32;
    localparam int DIV_ITERATIONS = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVIDE,
        S_FIXUP,
        S_DONE
    } div_state_t;

    function automatic logic [DIV_WIDTH-1:0] magnitude(input logic [DIV_WIDTH-1:0] value);
        return value[DIV_WIDTH-1] ? -value : value;
    endfunction

endpackage

// File: rtl/division_32_bit.sv
// Multi-cycle signed 32-bit divider: unsigned restoring core on operand
// magnitudes, sign fix-up afterwards. result = {remainder, quotient}.
module division_32_bit
    import div_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [DIV_WIDTH-1:0]     dividend,
    input  logic [DIV_WIDTH-1:0]     divisor,
    output logic                     busy,
    output logic                     done,
    output logic                     div_by_zero,
    output logic [2*DIV_WIDTH-1:0]   result
);

    localparam logic [4:0] LAST_ITER = 5'(DIV_ITERATIONS - 1);

    div_state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0]     dvd_mag_q, dvd_mag_d;
    logic [DIV_WIDTH-1:0]     dsr_mag_q, dsr_mag_d;
    logic                     dvd_neg_q, dvd_neg_d;
    logic                     dsr_neg_q, dsr_neg_d;
    logic [2*DIV_WIDTH-1:0]   work_q, work_d;
    logic [4:0]               count_q, count_d;
    logic [2*DIV_WIDTH-1:0]   result_q, result_d;
    logic                     dbz_q, dbz_d;

    logic [DIV_WIDTH:0]       partial;
    logic [DIV_WIDTH:0]       trial;
    logic [DIV_WIDTH-1:0]     quo_fix;
    logic [DIV_WIDTH-1:0]     rem_fix;
    logic [DIV_WIDTH-1:0]     dvd_signed;

    // Dividend bits enter MSB-first; a borrow out of the trial subtract means restore.
    always_comb begin
        partial    = {work_q[2*DIV_WIDTH-1:DIV_WIDTH], dvd_mag_q[LAST_ITER - count_q]};
        trial      = partial - {1'b0, dsr_mag_q};
        quo_fix    = (dvd_neg_q ^ dsr_neg_q) ? -work_q[DIV_WIDTH-1:0] : work_q[DIV_WIDTH-1:0];
        rem_fix    = dvd_neg_q ? -work_q[2*DIV_WIDTH-1:DIV_WIDTH] : work_q[2*DIV_WIDTH-1:DIV_WIDTH];
        dvd_signed = dvd_neg_q ? -dvd_mag_q : dvd_mag_q;
    end

    always_comb begin
        state_d   = state_q;
        dvd_mag_d = dvd_mag_q;
        dsr_mag_d = dsr_mag_q;
        dvd_neg_d = dvd_neg_q;
        dsr_neg_d = dsr_neg_q;
        work_d    = work_q;
        count_d   = count_q;
        result_d  = result_q;
        dbz_d     = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvd_mag_d = magnitude(dividend);
                    dsr_mag_d = magnitude(divisor);
                    dvd_neg_d = dividend[DIV_WIDTH-1];
                    dsr_neg_d = divisor[DIV_WIDTH-1];
                    work_d    = '0;
                    count_d   = '0;
                    state_d   = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                if (trial[DIV_WIDTH]) begin
                    work_d = {partial[DIV_WIDTH-1:0], work_q[DIV_WIDTH-2:0], 1'b0};
                end else begin
                    work_d = {trial[DIV_WIDTH-1:0], work_q[DIV_WIDTH-2:0], 1'b1};
                end
                count_d = count_q + 5'd1;
                if (count_q == LAST_ITER) begin
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                // Zero divisor: all-ones quotient and the original dividend as remainder.
                if (dsr_mag_q == '0) begin
                    result_d = {dvd_signed, {DIV_WIDTH{1'b1}}};
                    dbz_d    = 1'b1;
                end else begin
                    result_d = {rem_fix, quo_fix};
                    dbz_d    = 1'b0;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            dvd_mag_q <= '0;
            dsr_mag_q <= '0;
            dvd_neg_q <= 1'b0;
            dsr_neg_q <= 1'b0;
            work_q    <= '0;
            count_q   <= '0;
            result_q  <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dvd_mag_q <= dvd_mag_d;
            dsr_mag_q <= dsr_mag_d;
            dvd_neg_q <= dvd_neg_d;
            dsr_neg_q <= dsr_neg_d;
            work_q    <= work_d;
            count_q   <= count_d;
            result_q  <= result_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign div_by_zero = dbz_q;
    assign result      = result_q;

endmodule

// File: tb/tb_division_32_bit.sv
// Directed-vector bench for division_32_bit with hand-computed results,
// latency, reset-abort, ignored-start and result-hold checks.
module tb_division_32_bit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [63:0] result;

    int checks      = 0;
    int failures    = 0;
    int cycle       = 0;
    int done_pulses = 0;
    int pulses_before;
    logic [63:0] last_result = '0;

    division_32_bit dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .result      (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (done) done_pulses++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cycle++;
    endtask

    // Holds start for one edge; cycle 1 is the cycle right after the accepting edge.
    task automatic applyStimulus(input logic [31:0] dvd, input logic [31:0] dsr);
        @(negedge clock);
        dividend = dvd;
        divisor  = dsr;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        cycle = 1;
    endtask

    task automatic waitDone(input string tag);
        while (!done && cycle < 100) step();
        checkOutput({tag, " latency"}, 64'(cycle), 64'd34);
    endtask

    task automatic runOp(input string tag, input logic [31:0] dvd, input logic [31:0] dsr,
                         input logic [63:0] exp_result, input logic exp_dbz);
        applyStimulus(dvd, dsr);
        checkOutput({tag, " busy"}, 64'(busy), 64'd1);
        while (cycle < 20) step();
        checkOutput({tag, " hold"}, result, last_result);
        waitDone(tag);
        checkOutput({tag, " result"}, result, exp_result);
        checkOutput({tag, " dbz"}, 64'(div_by_zero), 64'(exp_dbz));
        step();
        checkOutput({tag, " done drop"}, 64'(done), 64'd0);
        checkOutput({tag, " idle"}, 64'(busy), 64'd0);
        last_result = exp_result;
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) step();
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset dbz", 64'(div_by_zero), 64'd0);
        checkOutput("reset result", result, 64'd0);
        reset = 1'b0;
        step();

        runOp("100/7", 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0);
        runOp("-100/7", 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 1'b0);
        runOp("100/-7", 32'd100, 32'hFFFFFFF9, 64'h00000002_FFFFFFF2, 1'b0);
        runOp("min/-1", 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0);
        runOp("5/0", 32'd5, 32'd0, 64'h00000005_FFFFFFFF, 1'b1);
        runOp("-9/0", 32'hFFFFFFF7, 32'd0, 64'hFFFFFFF7_FFFFFFFF, 1'b1);

        // Reset in the middle of an operation must abort it silently.
        pulses_before = done_pulses;
        applyStimulus(32'd1000, 32'd3);
        while (cycle < 10) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("abort busy", 64'(busy), 64'd0);
        checkOutput("abort result", result, 64'd0);
        checkOutput("abort dbz", 64'(div_by_zero), 64'd0);
        repeat (40) step();
        checkOutput("abort no done", 64'(done_pulses), 64'(pulses_before));
        last_result = '0;
        runOp("9/3", 32'd9, 32'd3, 64'h00000000_00000003, 1'b0);

        // start during DIVIDE and during DONE is ignored.
        pulses_before = done_pulses;
        applyStimulus(32'd50, 32'd5);
        while (cycle < 5) step();
        dividend = 32'd7;
        divisor  = 32'd2;
        start    = 1'b1;
        step();
        start = 1'b0;
        waitDone("50/5");
        checkOutput("50/5 result", result, 64'h00000000_0000000A);
        start = 1'b1;
        step();
        start = 1'b0;
        checkOutput("start in done ignored", 64'(busy), 64'd0);
        repeat (40) step();
        checkOutput("single done pulse", 64'(done_pulses - pulses_before), 64'd1);
        checkOutput("50/5 result held", result, 64'h00000000_0000000A);
        last_result = 64'h00000000_0000000A;

        runOp("6/4", 32'd6, 32'd4, 64'h00000002_00000001, 1'b0);
        runOp("max/1", 32'h7FFFFFFF, 32'd1, 64'h00000000_7FFFFFFF, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/division_32_bit.md
DIVISION_32_BIT -- requirements
Module: division_32_bit

Interface
REQ-001 Parameters SHALL be none; operand width is fixed at 32 bits.
REQ-002 clock  input  1  single clock; all state changes occur on its rising edge.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 dividend  input  32  signed two's-complement dividend; sampled with accepted start.
REQ-006 divisor  input  32  signed two's-complement divisor; sampled with accepted start.
REQ-007 busy  output  1  high from the edge accepting start until the edge leaving DONE.
REQ-008 done  output  1  one-cycle pulse; result valid.
REQ-009 div_by_zero  output  1  registered with result; high when captured divisor was 0.
REQ-010 result  output  64  {remainder[31:0], quotient[31:0]}; same HI/LO packing as the 32-bit multiplier result.

Function
REQ-011 The block SHALL implement the FSM IDLE -> DIVIDE -> FIXUP -> DONE -> IDLE.
REQ-012 In IDLE with start=1, the block SHALL latch |dividend|, |divisor| and both sign bits, clear the 64-bit remainder/quotient shift register and the 5-bit iteration counter, and enter DIVIDE.
REQ-013 DIVIDE SHALL perform one unsigned restoring step per cycle (shift left, trial-subtract the divisor magnitude, set the quotient bit if non-negative) for exactly 32 cycles, then enter FIXUP.
REQ-014 FIXUP SHALL negate the quotient when the signs differ and negate the remainder when the dividend was negative, then register result and div_by_zero and enter DONE.
REQ-015 Quotient SHALL truncate toward zero; the remainder sign SHALL follow the dividend; dividend = quotient*divisor + remainder (mod 2^32).
REQ-016 done SHALL be high only in DONE, 34 cycles after the edge accepting start; DONE SHALL return to IDLE on the next edge.
REQ-017 With divisor = 0, the block SHALL keep the same latency and return quotient 0xFFFFFFFF, remainder = dividend (unmodified), and div_by_zero = 1.
REQ-018 0x80000000 / 0xFFFFFFFF SHALL return quotient 0x80000000 and remainder 0 with no error flag (32-bit wrap).
REQ-019 Magnitude of 0x80000000 SHALL be taken as unsigned 0x80000000 (no saturation).
REQ-020 start while busy=1 SHALL be ignored; operand changes after acceptance SHALL not affect the operation.
REQ-021 start asserted in the DONE cycle SHALL be ignored; a new operation can be accepted from IDLE at the earliest.
REQ-022 result and div_by_zero SHALL hold their values from the last completion until the next FIXUP.

Reset
REQ-023 reset=1 at a rising edge SHALL force IDLE, busy=0, done=0, div_by_zero=0, result=0, and clear the counter and working registers.
REQ-024 reset SHALL take priority over start and over any in-flight operation; an aborted operation SHALL never produce done.

Structure
REQ-025 A shared package div_pkg SHALL hold the FSM state enumeration, DIV_WIDTH=32, and DIV_ITERATIONS=32.
REQ-026 The block SHALL be a single module with no sub-module; the restoring step SHALL be an inline combinational subtract/compare on the working register.

Verification
REQ-027 100 / 7 -> after 34 cycles done=1, result=0x00000002_0000000E, div_by_zero=0.
REQ-028 -100 / 7 -> result=0xFFFFFFFE_FFFFFFF2; 100 / -7 -> result=0x00000002_FFFFFFF2.
REQ-029 0x80000000 / 0xFFFFFFFF -> result=0x00000000_80000000, div_by_zero=0; 5 / 0 -> result=0x00000005_FFFFFFFF, div_by_zero=1, same 34-cycle latency.
REQ-030 Start 1000 / 3, then pulse reset at cycle 10 -> busy=0, result=0, no done pulse; next start 9 / 3 -> result=0x00000000_00000003.
REQ-031 Start 50 / 5, then assert start with 7 / 2 during DIVIDE and during DONE -> exactly one done pulse, result=0x00000000_0000000A.
REQ-032 Back-to-back: after 6 / 4 completes, start 0x7FFFFFFF / 1 in IDLE -> done pulses 34 cycles later, result=0x00000000_7FFFFFFF; the previous result holds until then.
